// File: rtl/vc_channel.sv
// vc_channel: input virtual-channel controller (flit FIFO, route/VC/switch handshakes, credits).
// Define VC_ERR_EN to add a sticky err output for dropped pushes, credit overflow and stray body/tail flits.
module vc_channel #(
    parameter int unsigned FLIT_W   = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PORT_W   = 3,
    parameter int unsigned VC_W     = 4,
    parameter int unsigned CRED_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [FLIT_W-1:0]             in_flit,
    output logic                          credit_out,
    output logic                          route_req,
    input  logic                          route_ack,
    input  logic [PORT_W-1:0]             route_port,
    output logic                          vca_req,
    input  logic                          vca_grant,
    input  logic [VC_W-1:0]               vca_vc,
    input  logic [$clog2(CRED_MAX+1)-1:0] vca_cred,
    output logic                          sa_req,
    input  logic                          sa_grant,
    input  logic                          credit_in,
    output logic                          out_valid,
    output logic [FLIT_W-1:0]             out_flit,
    output logic [2:0]                    G,
    output logic [PORT_W-1:0]             R,
    output logic [VC_W-1:0]               O,
    output logic [$clog2(DEPTH+1)-1:0]    P,
    output logic [$clog2(CRED_MAX+1)-1:0] C
`ifdef VC_ERR_EN
    ,
    output logic                          err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned CW = $clog2(CRED_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ROUTING     = 3'd1,
        S_VC_WAIT     = 3'd2,
        S_ACTIVE      = 3'd3,
        S_CREDIT_WAIT = 3'd4
    } state_e;

    state_e            g_q, g_d;
    logic [PORT_W-1:0] r_q, r_d;
    logic [VC_W-1:0]   o_q, o_d;
    logic [PW-1:0]     p_q, p_d;
    logic [CW-1:0]     c_q, c_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic              credit_out_q, credit_out_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic [FLIT_W-1:0] mem_q [DEPTH];

    logic [FLIT_W-1:0] front_c;
    logic              fifo_empty_c, fifo_full_c, front_head_c, front_tail_c;
    logic              sa_pop_c, discard_c, pop_c, push_c;
    logic [CW-1:0]     c_acc_c;

    // type bit 1 marks a head (10/11), type bit 0 marks a tail (01/11)
    assign front_c      = mem_q[rd_ptr_q];
    assign fifo_empty_c = (p_q == PW'(DEPTH));
    assign fifo_full_c  = (p_q == '0);
    assign front_head_c = front_c[FLIT_W-1];
    assign front_tail_c = front_c[FLIT_W-2];

    assign route_req = (g_q == S_ROUTING);
    assign vca_req   = (g_q == S_VC_WAIT);
    assign sa_req    = (g_q == S_ACTIVE) && !fifo_empty_c && (c_q != '0);
    assign sa_pop_c  = sa_req && sa_grant;
`ifdef VC_ERR_EN
    assign discard_c = (g_q == S_IDLE) && !fifo_empty_c && !front_head_c;
`else
    assign discard_c = 1'b0;
`endif
    assign pop_c  = sa_pop_c || discard_c;
    assign push_c = in_valid && (!fifo_full_c || pop_c);

    // a grant and a returned credit in the same cycle cancel out
    always_comb begin
        c_acc_c = c_q;
        if (sa_pop_c && !credit_in) begin
            c_acc_c = c_q - CW'(1);
        end else if (credit_in && !sa_pop_c && (c_q != CW'(CRED_MAX))) begin
            c_acc_c = c_q + CW'(1);
        end
    end

    always_comb begin
        g_d          = g_q;
        r_d          = r_q;
        o_d          = o_q;
        c_d          = c_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        p_d          = p_q;
        out_valid_d  = sa_pop_c;
        credit_out_d = pop_c;
        out_flit_d   = sa_pop_c ? front_c : out_flit_q;

        if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (push_c && !pop_c) begin
            p_d = p_q - PW'(1);
        end else if (pop_c && !push_c) begin
            p_d = p_q + PW'(1);
        end

        case (g_q)
            S_IDLE: begin
                if (!fifo_empty_c && front_head_c) g_d = S_ROUTING;
            end
            S_ROUTING: begin
                if (route_ack) begin
                    r_d = route_port;
                    g_d = S_VC_WAIT;
                end
            end
            S_VC_WAIT: begin
                if (vca_grant) begin
                    o_d = vca_vc;
                    c_d = vca_cred;
                    g_d = (vca_cred != '0) ? S_ACTIVE : S_CREDIT_WAIT;
                end
            end
            S_ACTIVE: begin
                c_d = c_acc_c;
                if (sa_pop_c) begin
                    if (front_tail_c) begin
                        g_d = S_IDLE;
                        r_d = '0;
                        o_d = '0;
                        c_d = '0;
                    end else if (c_acc_c == '0) begin
                        g_d = S_CREDIT_WAIT;
                    end
                end
            end
            S_CREDIT_WAIT: begin
                c_d = c_acc_c;
                if (c_acc_c != '0) g_d = S_ACTIVE;
            end
            default: g_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_q          <= S_IDLE;
            r_q          <= '0;
            o_q          <= '0;
            c_q          <= '0;
            p_q          <= PW'(DEPTH);
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            credit_out_q <= 1'b0;
            out_flit_q   <= '0;
        end else begin
            g_q          <= g_d;
            r_q          <= r_d;
            o_q          <= o_d;
            c_q          <= c_d;
            p_q          <= p_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            out_valid_q  <= out_valid_d;
            credit_out_q <= credit_out_d;
            out_flit_q   <= out_flit_d;
        end
    end

    // storage is not reset; occupancy lives in the pointers and P
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= in_flit;
    end

`ifdef VC_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((in_valid && fifo_full_c && !pop_c) ||
            (credit_in && (c_q == CW'(CRED_MAX))) || discard_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err = err_q;
`endif

    assign G          = g_q;
    assign R          = r_q;
    assign O          = o_q;
    assign P          = p_q;
    assign C          = c_q;
    assign out_valid  = out_valid_q;
    assign credit_out = credit_out_q;
    assign out_flit   = out_flit_q;

endmodule

// File: tb/tb_vc_channel.sv
// tb_vc_channel: directed scenarios plus randomized packet traffic checked against a queue-based reference model.
module tb_vc_channel;

    localparam int unsigned FLIT_W   = 32;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PORT_W   = 3;
    localparam int unsigned VC_W     = 4;
    localparam int unsigned CRED_MAX = 4;
    localparam int unsigned PW       = $clog2(DEPTH + 1);
    localparam int unsigned CW       = $clog2(CRED_MAX + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [FLIT_W-1:0] in_flit = '0;
    logic              credit_out;
    logic              route_req;
    logic              route_ack = 1'b0;
    logic [PORT_W-1:0] route_port = '0;
    logic              vca_req;
    logic              vca_grant = 1'b0;
    logic [VC_W-1:0]   vca_vc = '0;
    logic [CW-1:0]     vca_cred = '0;
    logic              sa_req;
    logic              sa_grant = 1'b0;
    logic              credit_in = 1'b0;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic [2:0]        G;
    logic [PORT_W-1:0] R;
    logic [VC_W-1:0]   O;
    logic [PW-1:0]     P;
    logic [CW-1:0]     C;
`ifdef VC_ERR_EN
    logic              err;
`endif

    vc_channel #(
        .FLIT_W(FLIT_W), .DEPTH(DEPTH), .PORT_W(PORT_W), .VC_W(VC_W), .CRED_MAX(CRED_MAX)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .credit_out(credit_out),
        .route_req(route_req), .route_ack(route_ack), .route_port(route_port),
        .vca_req(vca_req), .vca_grant(vca_grant), .vca_vc(vca_vc), .vca_cred(vca_cred),
        .sa_req(sa_req), .sa_grant(sa_grant), .credit_in(credit_in),
        .out_valid(out_valid), .out_flit(out_flit),
        .G(G), .R(R), .O(O), .P(P), .C(C)
`ifdef VC_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // reference model: packet state as integers, buffer as a queue
    int                m_g, m_r, m_o, m_c;
    logic [FLIT_W-1:0] m_q [$];
    bit                m_ov, m_co, m_err;
    logic [FLIT_W-1:0] m_of;

    int n_cmp = 0;
    int n_mis = 0;
    int prod_rem = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_g = 0; m_r = 0; m_o = 0; m_c = 0;
        m_q.delete();
        m_ov = 1'b0; m_co = 1'b0; m_err = 1'b0; m_of = '0;
    endtask

    function automatic bit model_sa_req();
        return (m_g == 3) && (m_q.size() > 0) && (m_c > 0);
    endfunction

    // advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic [FLIT_W-1:0] front;
        bit                pop, disc, acc_push, head, tail;
        int                nc;
        int                size0;
        size0 = m_q.size();
        front = (size0 > 0) ? m_q[0] : '0;
        head  = front[FLIT_W-1];
        tail  = front[FLIT_W-2];
        pop   = model_sa_req() && sa_grant;
        disc  = 1'b0;
`ifdef VC_ERR_EN
        disc = (m_g == 0) && (size0 > 0) && !head;
        if ((in_valid && size0 == DEPTH && !pop && !disc) || (credit_in && m_c == CRED_MAX) || disc)
            m_err = 1'b1;
`endif
        acc_push = in_valid && ((size0 < DEPTH) || pop || disc);
        m_ov = pop;
        m_co = pop || disc;
        if (pop) m_of = front;
        case (m_g)
            0: if (size0 > 0 && head) m_g = 1;
            1: if (route_ack) begin m_r = int'(route_port); m_g = 2; end
            2: if (vca_grant) begin
                   m_o = int'(vca_vc);
                   m_c = int'(vca_cred);
                   m_g = (m_c > 0) ? 3 : 4;
               end
            default: begin
                nc = m_c;
                if (credit_in && !pop) nc = (m_c < CRED_MAX) ? m_c + 1 : m_c;
                else if (pop && !credit_in) nc = m_c - 1;
                if (pop && tail) begin
                    m_g = 0; m_r = 0; m_o = 0; m_c = 0;
                end else begin
                    m_c = nc;
                    if (m_g == 3 && nc == 0) m_g = 4;
                    else if (m_g == 4 && nc > 0) m_g = 3;
                end
            end
        endcase
        if (pop || disc) void'(m_q.pop_front());
        if (acc_push) m_q.push_back(in_flit);
    endtask

    task automatic compare_all();
        check_eq("G", 64'(G), 64'(m_g));
        check_eq("R", 64'(R), 64'(m_r));
        check_eq("O", 64'(O), 64'(m_o));
        check_eq("C", 64'(C), 64'(m_c));
        check_eq("P", 64'(P), 64'(DEPTH - m_q.size()));
        check_eq("out_valid", 64'(out_valid), 64'(m_ov));
        check_eq("credit_out", 64'(credit_out), 64'(m_co));
        if (m_ov) check_eq("out_flit", 64'(out_flit), 64'(m_of));
        check_eq("route_req", 64'(route_req), 64'(m_g == 1));
        check_eq("vca_req", 64'(vca_req), 64'(m_g == 2));
        check_eq("sa_req", 64'(sa_req), 64'(model_sa_req()));
`ifdef VC_ERR_EN
        check_eq("err", 64'(err), 64'(m_err));
`endif
    endtask

    // one clock: model steps, DUT clocks, outputs compared at the falling edge, strobes cleared
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        in_valid  = 1'b0;
        route_ack = 1'b0;
        vca_grant = 1'b0;
        sa_grant  = 1'b0;
        credit_in = 1'b0;
    endtask

    task automatic push_flit(input logic [FLIT_W-1:0] f);
        in_valid = 1'b1;
        in_flit  = f;
        tick();
    endtask

    task automatic route_and_grant(input int port, input int vc, input int cred);
        route_ack = 1'b1; route_port = PORT_W'(port); tick();
        vca_grant = 1'b1; vca_vc = VC_W'(vc); vca_cred = CW'(cred); tick();
    endtask

    task automatic gen_flit(output logic [FLIT_W-1:0] f);
        logic [FLIT_W-3:0] pay;
        int                len;
        pay = (FLIT_W-2)'($urandom);
        if (prod_rem == 0) begin
            len = int'($urandom_range(4, 1));
            f = {(len == 1) ? 2'b11 : 2'b10, pay};
            prod_rem = len - 1;
        end else begin
            f = {(prod_rem == 1) ? 2'b01 : 2'b00, pay};
            prod_rem--;
        end
    endtask

    logic [FLIT_W-1:0] f;
    logic [FLIT_W-1:0] singles [5];

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b1;

        // single-flit packet
        f = {2'b11, 30'h0000_1234};
        push_flit(f);
        tick();
        check_eq("t1_route_req", 64'(route_req), 64'd1);
        route_ack = 1'b1; route_port = 3'd3; tick();
        check_eq("t1_R", 64'(R), 64'd3);
        vca_grant = 1'b1; vca_vc = 4'd5; vca_cred = CW'(4); tick();
        check_eq("t1_O", 64'(O), 64'd5);
        check_eq("t1_C", 64'(C), 64'd4);
        sa_grant = 1'b1; tick();
        check_eq("t1_out_valid", 64'(out_valid), 64'd1);
        check_eq("t1_out_flit", 64'(out_flit), 64'(f));
        check_eq("t1_credit_out", 64'(credit_out), 64'd1);
        check_eq("t1_G", 64'(G), 64'd0);
        check_eq("t1_P", 64'(P), 64'd4);
        tick();
        check_eq("t1_out_valid_drop", 64'(out_valid), 64'd0);
        check_eq("t1_credit_out_drop", 64'(credit_out), 64'd0);

        // 4-flit packet with only 2 credits
        push_flit({2'b10, 30'h0A0});
        push_flit({2'b00, 30'h0A1});
        push_flit({2'b00, 30'h0A2});
        push_flit({2'b01, 30'h0A3});
        route_and_grant(1, 2, 2);
        sa_grant = 1'b1; tick();
        sa_grant = 1'b1; tick();
        check_eq("t2_G_cwait", 64'(G), 64'd4);
        check_eq("t2_C_zero", 64'(C), 64'd0);
        check_eq("t2_sa_req", 64'(sa_req), 64'd0);
        sa_grant = 1'b1; credit_in = 1'b1; tick();
        sa_grant = 1'b1; tick();
        credit_in = 1'b1; tick();
        sa_grant = 1'b1; tick();
        check_eq("t2_last_flit", 64'(out_flit), 64'({2'b01, 30'h0A3}));
        check_eq("t2_G_idle", 64'(G), 64'd0);
        check_eq("t2_P", 64'(P), 64'd4);

        // fill, overflow, push+pop while full, order across pointer wrap
        for (int i = 0; i < 5; i++) singles[i] = {2'b11, 30'(32'h100 + i)};
        for (int i = 0; i < 4; i++) push_flit(singles[i]);
        check_eq("t3_P_full", 64'(P), 64'd0);
        push_flit({2'b11, 30'h3FF});
        check_eq("t3_P_drop", 64'(P), 64'd0);
`ifdef VC_ERR_EN
        check_eq("t3_err", 64'(err), 64'd1);
`endif
        route_and_grant(2, 1, 4);
        sa_grant = 1'b1; in_valid = 1'b1; in_flit = singles[4]; tick();
        check_eq("t4_P_pushpop", 64'(P), 64'd0);
        check_eq("t4_flit0", 64'(out_flit), 64'(singles[0]));
        for (int k = 1; k < 5; k++) begin
            tick();
            route_and_grant(k, k, 4);
            sa_grant = 1'b1; tick();
            check_eq("t4_order", 64'(out_flit), 64'(singles[k]));
        end

        // credit accounting corner cases
        push_flit({2'b10, 30'h0B0});
        push_flit({2'b00, 30'h0B1});
        push_flit({2'b00, 30'h0B2});
        push_flit({2'b01, 30'h0B3});
        route_and_grant(4, 7, 2);
        sa_grant = 1'b1; credit_in = 1'b1; tick();
        check_eq("t5_C_cancel", 64'(C), 64'd2);
        credit_in = 1'b1; tick();
        credit_in = 1'b1; tick();
        credit_in = 1'b1; tick();
        check_eq("t5_C_sat", 64'(C), 64'd4);
        repeat (3) begin sa_grant = 1'b1; tick(); end
        check_eq("t5_G_idle", 64'(G), 64'd0);

        // reset asserted mid-packet
        push_flit({2'b10, 30'h0D0});
        push_flit({2'b00, 30'h0D1});
        route_and_grant(5, 3, 3);
        sa_grant = 1'b1; tick();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_eq("t6_G", 64'(G), 64'd0);
        check_eq("t6_P", 64'(P), 64'(DEPTH));
        check_eq("t6_C", 64'(C), 64'd0);
        check_eq("t6_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        push_flit({2'b11, 30'h0E0});
        tick();
        check_eq("t6_restart", 64'(G), 64'd1);
        route_and_grant(6, 9, 1);
        sa_grant = 1'b1; tick();

`ifdef VC_ERR_EN
        // stray body flit at the front in IDLE is discarded
        push_flit({2'b00, 30'h0F0});
        tick();
        check_eq("t7_discard_P", 64'(P), 64'(DEPTH));
`endif

        // randomized well-formed packet traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sa_grant   = ($urandom_range(9) < 6);
            route_ack  = ($urandom_range(3) == 0);
            route_port = PORT_W'($urandom);
            vca_grant  = ($urandom_range(3) == 0);
            vca_vc     = VC_W'($urandom);
            vca_cred   = CW'($urandom_range(CRED_MAX));
            credit_in  = ($urandom_range(9) < 3);
            in_flit    = FLIT_W'($urandom);
            if ($urandom_range(1) == 1 && ((m_q.size() < DEPTH) || (model_sa_req() && sa_grant))) begin
                gen_flit(f);
                in_valid = 1'b1;
                in_flit  = f;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
